// File: rtl/restoring_divider_4bit.sv
// ---------------------------------------------------------------------------
// restoring_divider_4bit
//   Multi-cycle unsigned restoring divider. One quotient bit is resolved per
//   clock: a dividend bit is shifted into the partial remainder, and the
//   divisor is trial-subtracted on a ripple-borrow chain of 1-bit
//   full-subtractor cells. The final borrow of each trial decides the
//   quotient bit and whether the trial difference is kept.
//
//   Ports
//     clk          rising-edge clock, all state
//     rst          synchronous active-high reset (aborts any division)
//     start        request, accepted when busy==0 (IDLE or DONE cycle)
//     dividend     unsigned dividend, sampled on an accepted start
//     divisor      unsigned divisor, sampled on an accepted start
//     busy         high while iterating (exactly WIDTH cycles)
//     done         one-cycle pulse, results valid
//     quotient     quotient, held until the next completion
//     remainder    remainder, held until the next completion
//     div_by_zero  divisor was zero; updated with quotient/remainder
// ---------------------------------------------------------------------------
module restoring_divider_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d;         // partial remainder
    logic [WIDTH-1:0]   dvd_q, dvd_d;         // dividend shift register
    logic [WIDTH-1:0]   dvs_q, dvs_d;         // latched divisor
    logic [WIDTH-1:0]   qsh_q, qsh_d;         // quotient shift register
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dz_q, dz_d;

    // ------------------------------------------------------------------
    // Trial subtraction: R' - {0,divisor} over WIDTH+1 bits.
    // The partial remainder is always below the divisor after a step, so
    // only its low WIDTH bits are stored; R' needs the extra MSB because
    // the shift can double it.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH-1:0] trial_diff;
    logic [WIDTH+1:0] borrow;
    logic             q_bit;
    logic             last_iter;

    assign r_shift   = {rem_q, dvd_q[WIDTH-1]};
    assign sub_b     = {1'b0, dvs_q};
    assign borrow[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : g_fs
            assign borrow[gi+1] = (~r_shift[gi] & sub_b[gi])
                                | (~(r_shift[gi] ^ sub_b[gi]) & borrow[gi]);
            // The top difference bit is zero whenever the trial is kept
            // (no borrow means the result is below the divisor), so it is
            // not materialised.
            if (gi < WIDTH) begin : g_diff
                assign trial_diff[gi] = r_shift[gi] ^ sub_b[gi] ^ borrow[gi];
            end
        end
    endgenerate

    assign q_bit     = ~borrow[WIDTH+1];
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: state_d = start ? S_CALC : S_IDLE;
            S_CALC:         state_d = last_iter ? S_DONE : S_CALC;
            default:        state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q == S_CALC);
        done = (state_q == S_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        qsh_d       = qsh_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;

        if (state_q == S_CALC) begin
            rem_d = q_bit ? trial_diff : r_shift[WIDTH-1:0];
            dvd_d = dvd_q << 1;
            qsh_d = (qsh_q << 1) | WIDTH'(q_bit);
            cnt_d = cnt_q + CNT_W'(1);
            if (last_iter) begin
                quotient_d  = (qsh_q << 1) | WIDTH'(q_bit);
                remainder_d = q_bit ? trial_diff : r_shift[WIDTH-1:0];
                dz_d        = (dvs_q == '0);
            end
        end else if (start) begin
            // IDLE or DONE: accept a new request.
            rem_d = '0;
            dvd_d = dividend;
            dvs_d = divisor;
            qsh_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            qsh_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
        end else begin
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            qsh_q       <= qsh_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_restoring_divider_4bit.sv
// ---------------------------------------------------------------------------
// tb_restoring_divider_4bit
//   Scoreboard bench: stimulus pushes the expected quotient/remainder/
//   div_by_zero and the expected done cycle; a monitor pops and compares
//   on every done pulse, checks reset values, busy length and that the
//   outputs hold between completions.
// ---------------------------------------------------------------------------
module tb_restoring_divider_4bit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    restoring_divider_4bit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           cyc;
        int           a;
        int           b;
    } exp_t;

    exp_t         sb[$];
    exp_t         e;
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           busy_run = 0;
    int           txn = 0;
    logic [W-1:0] hold_q = '0;
    logic [W-1:0] hold_r = '0;
    logic         hold_dz = 1'b0;

    task automatic check(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0d want=%0d", nm, cyc, got, want);
        end
    endtask

    // Wait for the divider to be free, then present a request and record
    // what it must produce. Done is due WIDTH+1 monitor cycles after the
    // negedge that drives start (accept edge + WIDTH iterations).
    task automatic issue(input int a, input int b, input int eq, input int er, input int edz);
        exp_t x;
        int   n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            check("issue_wait_busy", int'(busy), 0);
        end else begin
            dividend = W'(a);
            divisor  = W'(b);
            start    = 1'b1;
            x.q   = W'(eq);
            x.r   = W'(er);
            x.dz  = edz[0];
            x.cyc = cyc + W + 1;
            x.a   = a;
            x.b   = b;
            sb.push_back(x);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic ref_issue(input int a, input int b);
        if (b == 0) issue(a, b, (1 << W) - 1, a, 1);
        else        issue(a, b, a / b, a % b, 0);
    endtask

    // Monitor
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                sb.delete();
                hold_q   = '0;
                hold_r   = '0;
                hold_dz  = 1'b0;
                busy_run = 0;
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_quotient", int'(quotient), 0);
                check("rst_remainder", int'(remainder), 0);
                check("rst_div_by_zero", int'(div_by_zero), 0);
            end else if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("quotient", int'(quotient), int'(e.q));
                    check("remainder", int'(remainder), int'(e.r));
                    check("div_by_zero", int'(div_by_zero), int'(e.dz));
                    check("done_cycle", cyc, e.cyc);
                    check("busy_cycles", busy_run, W);
                    check("busy_at_done", int'(busy), 0);
                    hold_q  = e.q;
                    hold_r  = e.r;
                    hold_dz = e.dz;
                    txn++;
                    $display("txn %0d: %0d/%0d -> q=%0d r=%0d dz=%0d at cycle %0d",
                             txn, e.a, e.b, quotient, remainder, div_by_zero, cyc);
                end
                busy_run = 0;
            end else begin
                if (busy) busy_run++;
                check("hold_quotient", int'(quotient), int'(hold_q));
                check("hold_remainder", int'(remainder), int'(hold_r));
                check("hold_div_by_zero", int'(div_by_zero), int'(hold_dz));
            end
        end
    end

    // Stimulus
    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic: 13/3
        issue(13, 3, 4, 1, 0);
        idle();

        // Back-to-back with start held through the DONE cycle
        issue(15, 15, 1, 0, 0);
        issue(2, 9, 0, 2, 0);
        idle();

        // Divide by zero
        issue(7, 0, 15, 7, 1);
        idle();

        // Start while busy is ignored
        issue(12, 5, 2, 2, 0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dividend = 4'd9;
        divisor  = 4'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Reset mid-operation: the 14/3 in flight must never complete
        issue(14, 3, 4, 2, 0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(14, 3, 4, 2, 0);
        idle();

        // Exhaustive, start held between requests
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                ref_issue(a, b);
            end
        end
        idle();

        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
